// File: rtl/bcd_key_entry_5.sv
// Decimal key-entry front end for the 5-digit BCD-to-binary converter.
// Optional range check on launch is enabled by defining RANGE_CHECK_EN.
module bcd_key_entry_5 #(
  parameter int NDIG = 5
`ifdef RANGE_CHECK_EN
  ,
  parameter logic [4*NDIG-1:0] LIMIT = 20'h65535
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key,
  output logic              key_ready,
  output logic [4*NDIG-1:0] bcd,
  output logic              conv_init,
  input  logic              conv_done,
  output logic [2:0]        count,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  localparam logic [2:0] NDIG_C = 3'(NDIG);

  state_t            state_r, state_n_s;
  logic [4*NDIG-1:0] bcd_r, bcd_n_s;
  logic [2:0]        count_r, count_n_s;
  logic              fresh_r, fresh_n_s;
  logic              guard_r, guard_n_s;
  logic              accept_s;
  logic              launch_ok_s;

  assign accept_s  = key_valid && (state_r == ST_ENTRY);
  assign key_ready = (state_r == ST_ENTRY);
  assign conv_init = (state_r == ST_LAUNCH);
  assign busy      = (state_r != ST_ENTRY);
  assign bcd       = bcd_r;
  assign count     = count_r;

`ifdef RANGE_CHECK_EN
  logic err_r;
  logic over_limit_s;

  // Packed-BCD order matches decimal order, so a plain compare suffices.
  assign over_limit_s = (bcd_r > LIMIT);
  assign launch_ok_s  = !over_limit_s;
  assign err          = err_r;

  // Error flag: set by a rejected enter, cleared by any other accepted key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= (key == 4'hE) && (count_r != 3'd0) && over_limit_s;
    end else begin
      err_r <= err_r;
    end
  end
`else
  assign launch_ok_s = 1'b1;
  assign err         = 1'b0;
`endif

  // State and entry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_ENTRY;
      bcd_r   <= '0;
      count_r <= 3'd0;
      fresh_r <= 1'b0;
      guard_r <= 1'b0;
    end else begin
      state_r <= state_n_s;
      bcd_r   <= bcd_n_s;
      count_r <= count_n_s;
      fresh_r <= fresh_n_s;
      guard_r <= guard_n_s;
    end
  end

  // Next-state and entry-edit logic.
  always_comb begin
    state_n_s = state_r;
    bcd_n_s   = bcd_r;
    count_n_s = count_r;
    fresh_n_s = fresh_r;
    guard_n_s = guard_r;
    case (state_r)
      ST_ENTRY: begin
        if (!accept_s) begin
          state_n_s = ST_ENTRY;
        end else if (key <= 4'd9) begin
          // A finished result stays on display until the next digit replaces it.
          if (fresh_r) begin
            bcd_n_s   = {{(4*NDIG-4){1'b0}}, key};
            count_n_s = 3'd1;
            fresh_n_s = 1'b0;
          end else if (count_r < NDIG_C) begin
            bcd_n_s   = {bcd_r[4*NDIG-5:0], key};
            count_n_s = count_r + 3'd1;
          end else begin
            bcd_n_s = bcd_r;
          end
        end else begin
          case (key)
            4'hB: begin
              if (count_r != 3'd0) begin
                bcd_n_s   = {4'h0, bcd_r[4*NDIG-1:4]};
                count_n_s = count_r - 3'd1;
              end else begin
                count_n_s = count_r;
              end
              fresh_n_s = 1'b0;
            end
            4'hC: begin
              bcd_n_s   = '0;
              count_n_s = 3'd0;
              fresh_n_s = 1'b0;
            end
            4'hE: begin
              if ((count_r != 3'd0) && launch_ok_s) begin
                state_n_s = ST_LAUNCH;
              end else begin
                state_n_s = ST_ENTRY;
              end
            end
            default: state_n_s = ST_ENTRY;
          endcase
        end
      end
      ST_LAUNCH: begin
        state_n_s = ST_WAIT;
        guard_n_s = 1'b1;
      end
      ST_WAIT: begin
        // First WAIT cycle ignores done in case it is still high from before.
        if (guard_r) begin
          guard_n_s = 1'b0;
        end else if (conv_done) begin
          state_n_s = ST_ENTRY;
          fresh_n_s = 1'b1;
        end else begin
          state_n_s = ST_WAIT;
        end
      end
      default: state_n_s = ST_ENTRY;
    endcase
  end

endmodule

// File: tb/tb_bcd_key_entry_5.sv
// Directed self-checking bench for bcd_key_entry_5 (default build, no range check).
module tb_bcd_key_entry_5;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key;
  logic        key_ready;
  logic [19:0] bcd;
  logic        conv_init;
  logic        conv_done;
  logic [2:0]  count;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_key_entry_5 dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key(key),
    .key_ready(key_ready), .bcd(bcd), .conv_init(conv_init),
    .conv_done(conv_done), .count(count), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One key for one cycle; returns at the negedge after the accepting edge.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key       = k;
    @(negedge clk);
    key_valid = 1'b0;
    key       = 4'h0;
  endtask

  // Called right after an enter press; models a converter finishing ~20 cycles later.
  task automatic conv_wait(input int dly, input logic [19:0] held);
    int extra = 0;
    int unstable = 0;
    chk("init_pulse", conv_init, 1);
    chk("busy_rise", busy, 1);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (conv_init) extra++;
      if (bcd !== held || !busy || key_ready) unstable++;
    end
    chk("init_once", extra, 0);
    chk("wait_stable", unstable, 0);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    chk("ready_back", key_ready, 1);
    chk("busy_drop", busy, 0);
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b1; key = 4'h5; conv_done = 1'b0;
    repeat (3) @(negedge clk);
    key_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bcd", bcd, 20'h00000);
    chk("rst_count", count, 0);
    chk("rst_ready", key_ready, 1);
    chk("rst_init", conv_init, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);

    // Basic entry and conversion
    press(4'h1); press(4'h2); press(4'h3);
    chk("e123_bcd", bcd, 20'h00123);
    chk("e123_count", count, 3);
    press(4'hE);
    conv_wait(19, 20'h00123);
    chk("keep_result", bcd, 20'h00123);
    press(4'h7);
    chk("fresh_bcd", bcd, 20'h00007);
    chk("fresh_count", count, 1);

    // Overflow, backspace, ignored code, clear, empty enter
    press(4'hC);
    for (int d = 1; d <= 6; d++) press(4'(d));
    chk("full_bcd", bcd, 20'h12345);
    chk("full_count", count, 5);
    press(4'hB);
    chk("bs_bcd", bcd, 20'h01234);
    chk("bs_count", count, 4);
    press(4'hA);
    chk("ign_bcd", bcd, 20'h01234);
    press(4'hC);
    chk("clr_bcd", bcd, 20'h00000);
    chk("clr_count", count, 0);
    press(4'hE);
    chk("empty_enter_init", conv_init, 0);
    chk("empty_enter_ready", key_ready, 1);
    press(4'hB);
    chk("bs0_count", count, 0);

    // 65536 launches without range check; key held during WAIT
    press(4'h6); press(4'h5); press(4'h5); press(4'h3); press(4'h6);
    press(4'hE);
    chk("big_init", conv_init, 1);
    chk("big_err", err, 0);
    @(negedge clk);
    key_valid = 1'b1;
    key = 4'h4;
    repeat (5) @(negedge clk);
    chk("hold_count", count, 5);
    chk("hold_bcd", bcd, 20'h65536);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    chk("hold_ready", key_ready, 1);
    chk("hold_not_yet", bcd, 20'h65536);
    @(negedge clk);
    key_valid = 1'b0;
    chk("hold_acc_bcd", bcd, 20'h00004);
    chk("hold_acc_count", count, 1);

    // Stale done held high across enter
    press(4'hC);
    press(4'h9);
    conv_done = 1'b1;
    press(4'hE);
    chk("stale_init", conv_init, 1);
    @(negedge clk);
    chk("stale_guard1", busy, 1);
    @(negedge clk);
    chk("stale_guard2", busy, 1);
    @(negedge clk);
    chk("stale_exit", key_ready, 1);
    conv_done = 1'b0;

    // Reset in the middle of WAIT
    press(4'h4); press(4'h2);
    chk("pre_rst_bcd", bcd, 20'h00042);
    press(4'hE);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_bcd", bcd, 20'h00000);
    chk("arst_count", count, 0);
    chk("arst_ready", key_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", count, 0);
    chk("post_rst_init", conv_init, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_key_entry_5.md
# bcd_key_entry_5

Upstream digit-entry stage for the 5-digit BCD-to-binary converter. Accepts decimal keys (digits, backspace, clear, enter) over a valid/ready handshake and right-justifies them into a 20-bit packed-BCD word. On enter it pulses the converter's `init` and holds the BCD word stable until the converter's `done`. Keys are accepted only while no conversion is in flight.

## Interface
- `NDIG`, 5: digit capacity; `bcd` is 4*NDIG bits wide.
- `LIMIT`, 20'h65535: largest launchable value, as packed BCD; used only with range check.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `key_valid` in 1: key present.
- `key` in 4: 4'h0–4'h9 digit; 4'hB backspace; 4'hC clear; 4'hE enter; other codes are accepted and ignored.
- `key_ready` out 1: key accepted at an edge where `key_valid && key_ready`.
- `bcd` out 4*NDIG: packed BCD word; wires to converter `bcd`.
- `conv_init` out 1: one-cycle start pulse to converter `init`.
- `conv_done` in 1: converter `done`.
- `count` out 3: digits currently held, 0..NDIG.
- `busy` out 1: conversion in flight.
- `err` out 1: range error flag.

## Operation
- States: ENTRY, LAUNCH, WAIT. Reset state is ENTRY.
- Combinational outputs from state:
  - `key_ready` = (ENTRY).
  - `conv_init` = (LAUNCH).
  - `busy` = (LAUNCH or WAIT).
- Digit key:
  - If `fresh` is set, load `bcd` = {0, digit}, `count` = 1, and clear `fresh`.
  - Otherwise, if `count` < NDIG: `bcd` <= {bcd[4*NDIG-5:0], digit} and `count`+1.
  - At `count` == NDIG the digit is dropped with no state change.
- Backspace: if `count` > 0, `bcd` <= bcd >> 4 and `count`-1. At 0 it has no effect. Clears `fresh`.
- Clear: `bcd` = 0, `count` = 0, `err` = 0, `fresh` = 0.
- Enter:
  - `count` == 0: ignored.
  - Otherwise go to LAUNCH (subject to range check, see Configuration).
- LAUNCH: lasts exactly one cycle, then WAIT.
- WAIT:
  - `conv_done` is ignored in the first WAIT cycle, which guards against a stale done level.
  - From the second WAIT cycle, `conv_done` = 1 moves to ENTRY and sets `fresh`.
- `fresh`: the result entry stays visible after a conversion. The next digit key starts a new entry.
- `err` clears on any accepted key other than a rejected enter.
- Packed-BCD unsigned compare equals decimal magnitude compare, so the range test is a plain 20-bit `>` against `LIMIT`.

## Timing
- Reset values: `bcd` 0, `count` 0, `err` 0, `fresh` 0, `conv_init` 0, `busy` 0, `key_ready` 1.
- Keys presented while `rst` is high are not accepted.
- Enter accepted at edge N:
  - `conv_init` is high for cycle N..N+1 only.
  - The converter samples `init` at edge N+1.
  - `busy` rises after edge N.
- `bcd` and `count` are constant from edge N until return to ENTRY.
- Return latency: `key_ready` is high in the cycle after the edge that samples `conv_done` = 1 in WAIT (minimum 2 WAIT cycles).
- `rst` during LAUNCH or WAIT: immediate return to ENTRY and all reset values, asynchronously. `conv_init` drops at once.
- `key_valid` while `key_ready` is 0: not accepted. The source must hold the key.

## Configuration
- `RANGE_CHECK_EN` defined:
  - Enter with `bcd` > `LIMIT` does not launch.
  - It sets `err` = 1 and stays in ENTRY with `bcd` and `count` unchanged.
  - This guarantees the value fits 16 bits.
- `RANGE_CHECK_EN` undefined: enter always launches when `count` > 0. `err` is tied to 0.

## Test plan
- Reset, then release: `bcd` 20'h00000, `count` 0, `key_ready` 1, `conv_init` 0, `busy` 0.
- Keys 1,2,3,E with a converter stub raising `conv_done` 20 cycles after `init`:
  - `bcd` = 20'h00123, `count` 3.
  - `conv_init` is exactly one cycle, in the cycle after E is accepted.
  - `bcd` stays stable through WAIT and `key_ready` returns afterwards.
  - Then key 7 gives `bcd` 20'h00007, `count` 1.
- Keys 1..6:
  - `bcd` = 20'h12345, `count` 5; the 6th digit is dropped.
  - Backspace gives 20'h01234, `count` 4.
  - Clear gives 0, `count` 0.
  - E with `count` 0 gives no `conv_init`.
- With `RANGE_CHECK_EN`:
  - Keys 6,5,5,3,6,E give `err` 1 with no `conv_init`.
  - Backspace then 5,E gives `err` 0 and a launch with 20'h65535.
  - Without the macro, 65536 launches.
- During WAIT, hold `key_valid` with key 4: not accepted. After done, it is accepted.
- Hold `conv_done` high before enter: the WAIT guard cycle ignores it, and the exit occurs at the earliest on the second WAIT cycle.
- Assert `rst` mid-WAIT: `busy` 0, `bcd` 0, `count` 0 immediately. A later `conv_done` pulse has no effect.
